sel_mux_skid: RTL
=================

# sel_mux_skid

Parametrised N:1 operand-select mux with a registered output stage and a two-entry skid buffer, driven by a valid/ready handshake. It generalises the combinational 3:1 select used in the datapath to any input count and width. It sits between the operand sources (register file, EX/MEM result, MEM/WB result, immediate) and the ALU input stage. Its output register lets the select path close timing and absorb a one-cycle stall without losing an operand.

## Interface
- size, 16, data width of each input and of the output
- inputs, 3, number of selectable inputs (2..16)
- sel_w, $clog2(inputs) (min 1), width of select
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_bus  in  inputs*size  packed inputs; input k occupies bits [k*size +: size]
- select  in  sel_w  index of the input to capture
- in_valid  in  1  upstream offers {in_bus[select], select} this cycle
- in_ready  out  1  block can accept this cycle (registered)
- flush  in  1  discard all held entries
- out  out  size  selected data, registered
- out_sel  out  sel_w  select value captured with out
- out_err  out  1  captured select was >= inputs
- out_valid  out  1  out/out_sel/out_err hold a valid entry
- out_ready  in  1  downstream consumes the entry this cycle

## Operation
- Storage: main entry {data, sel, err, valid} drives the outputs; skid entry {data, sel, err, valid} is internal.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Captured data = in_bus[select*size +: size] when select < inputs. Otherwise data = 0 and err = 1. An out-of-range select is still a legal transfer: it consumes one slot and is not dropped.
- in_ready = !skid.valid. It depends only on registered state and has no combinational path from out_ready.
- Per-cycle update, in priority order:
  1. rst: both entries cleared.
  2. flush: both entries invalidated, even if in_valid is high. in_ready is 1 in the following cycle.
  3. Otherwise, if main is empty or being consumed:
     - If skid is valid: skid moves to main. An accepted input moves into skid (possible only when skid was empty, so it cannot happen in this case).
     - If skid is empty: an accepted input loads directly into main.
  4. If main is full and not consumed: an accepted input loads into skid.
- Output ordering is strictly FIFO, with a maximum of 2 entries.
- While out_valid && !out_ready, out/out_sel/out_err hold stable.

## Timing
- Reset values: out=0, out_sel=0, out_err=0, out_valid=0, in_ready=1. Skid contents are 0 and invalid.
- Latency: 1 cycle. An input accepted at edge N appears on out after edge N when main was empty or being consumed.
- Throughput: 1 transfer per cycle with out_ready held high. The skid stays empty in steady flow.
- Stall: out_ready low for one cycle with continuous input fills the skid. in_ready drops the next cycle. When out_ready returns, the skid drains to main and in_ready rises one cycle later.
- Both entries full with out_ready=1 and in_valid=1: no accept that cycle. Skid moves to main, and in_ready=1 next cycle.
- Simultaneous transfer in and out with skid empty: the new entry replaces main in the same edge. out_valid stays 1.
- rst or flush mid-stall: all pending entries are lost, out_valid=0 at the next cycle, and no stale data is ever presented.
- No combinational paths from inputs to outputs.

## Test plan
- size=4, inputs=3, in_bus={1010,1100,0011}, out_ready=1, select 0,1,2 on consecutive cycles. Required: out = 0011, 1100, 1010 on cycles 1..3, out_sel 0,1,2, out_valid continuous.
- Same data with select=3. Required: out=0000, out_err=1, out_sel=3, and the entry is still delivered.
- Stall: send 0011 (sel 0), then 1100 (sel 1), then 1010 (sel 2), holding out_ready=0 for two cycles. Required: in_ready=0 after the second accept, out holds 0011, and the 1010 offer is not accepted. After out_ready=1 the order is 0011, 1100, 1010 with none lost or duplicated.
- Change in_bus to {0101,0000,1111} while the skid holds 1100. Required: the delivered skid value remains 1100, not 0000.
- Flush with both entries full and in_valid=1. Required: out_valid=0 and in_ready=1 next cycle, and nothing is accepted that cycle.
- Assert rst during continuous streaming. Required: all outputs at reset values the next cycle, and streaming resumes with 1-cycle latency after rst falls.

Source files
------------

// File: rtl/sel_mux_skid.sv
// N:1 operand-select mux feeding a registered main entry backed by a one-deep skid entry.
// Valid/ready handshake on both sides; in_ready comes from registered state only.
module sel_mux_skid #(
  parameter int size   = 16,
  parameter int inputs = 3,
  parameter int sel_w  = (inputs > 1) ? $clog2(inputs) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [inputs*size-1:0]   in_bus,
  input  logic [sel_w-1:0]         select,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [size-1:0]          out,
  output logic [sel_w-1:0]         out_sel,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [size-1:0]  in_arr [inputs];
  logic [size-1:0]  cap_data;
  logic             cap_err;

  logic [size-1:0]  main_data_reg;
  logic [sel_w-1:0] main_sel_reg;
  logic             main_err_reg;
  logic             main_valid_reg;
  logic [size-1:0]  skid_data_reg;
  logic [sel_w-1:0] skid_sel_reg;
  logic             skid_err_reg;
  logic             skid_valid_reg;

  logic             accept;
  logic             main_free;

  genvar gi;
  generate
    for (gi = 0; gi < inputs; gi++) begin : g_slice
      assign in_arr[gi] = in_bus[gi*size +: size];
    end
  endgenerate

  // An out-of-range select still produces an entry: zero data flagged as an error.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int k = 0; k < inputs; k++) begin
      if (int'(select) == k) begin
        cap_data = in_arr[k];
        cap_err  = 1'b0;
      end
    end
  end

  assign accept    = in_valid && !skid_valid_reg;
  assign main_free = !main_valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_data_reg  <= '0;
      main_sel_reg   <= '0;
      main_err_reg   <= 1'b0;
      main_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_sel_reg   <= '0;
      skid_err_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        main_data_reg  <= skid_data_reg;
        main_sel_reg   <= skid_sel_reg;
        main_err_reg   <= skid_err_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        main_data_reg  <= cap_data;
        main_sel_reg   <= select;
        main_err_reg   <= cap_err;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new operand so nothing is lost.
      skid_data_reg  <= cap_data;
      skid_sel_reg   <= select;
      skid_err_reg   <= cap_err;
      skid_valid_reg <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid_reg;
  assign out       = main_data_reg;
  assign out_sel   = main_sel_reg;
  assign out_err   = main_err_reg;
  assign out_valid = main_valid_reg;

endmodule
